benes_route_sched: RTL and testbench

Configuration sequencer for the buffer interconnect's two Benes networks: R2M (RAM slots to modules) and M2R (modules to RAM slots).
- Holds a table of pre-computed switch configurations and accepts route commands (config index, beat count).
- Drives the registered module-select and slot-select stage buses.
- Tells the requester when to present data, and flags when routed data appears at the interconnect outputs, accounting for the interconnect's 3-stage register pipeline.

---
 rtl/benes_route_sched.sv | 107 ++++++++++
 tb/tb_benes_route_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/benes_route_sched.sv
// benes_route_sched: switch-config table and route-command sequencer for the R2M/M2R Benes networks
module benes_route_sched #(
   parameter int STAGE_NUM  = 9,
   parameter int SWITCH_NUM = 16,
   parameter int NUM_CFG    = 8,
   parameter int CFG_IDX_W  = 3,
   parameter int LEN_W      = 8,
   parameter int PIPE_LAT   = 3,
   localparam int STG_W     = $clog2(STAGE_NUM),
   localparam int SEL_W     = STAGE_NUM * SWITCH_NUM
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_we,
   input  logic [CFG_IDX_W-1:0]  cfg_idx,
   input  logic                  cfg_net,
   input  logic [STG_W-1:0]      cfg_stage,
   input  logic [SWITCH_NUM-1:0] cfg_wdata,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [CFG_IDX_W-1:0]  cmd_cfg,
   input  logic [LEN_W-1:0]      cmd_len,
   output logic [SEL_W-1:0]      o_module_select,
   output logic [SEL_W-1:0]      o_slot_select,
   output logic                  o_issue,
   output logic                  o_out_valid,
   output logic                  o_done,
   output logic                  o_err,
   output logic                  o_busy
);
   localparam int TAB_N = 2 ** CFG_IDX_W;
   localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_HOLD = 2'd2;

   logic [SEL_W-1:0]    r_tab_m [TAB_N];
   logic [SEL_W-1:0]    r_tab_s [TAB_N];
   logic [SEL_W-1:0]    r_msel, r_ssel;
   logic [1:0]          r_state, w_next;
   logic [LEN_W-1:0]    r_cnt;
   logic [PIPE_LAT-1:0] r_vld, r_lst;
   logic                r_err;
   logic                w_wr_ok, w_accept, w_cmd_ok, w_last;

   assign w_wr_ok  = cfg_we && (32'(cfg_stage) < STAGE_NUM) && (32'(cfg_idx) < NUM_CFG);
   assign w_accept = cmd_valid && cmd_ready;
   assign w_cmd_ok = (cmd_len != '0) && (32'(cmd_cfg) < NUM_CFG);
   assign w_last   = o_issue && (r_cnt == LEN_W'(1));

   // config table: one stage word per write, out-of-range stages dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < TAB_N; i++) begin
            r_tab_m[i] <= '0;
            r_tab_s[i] <= '0;
         end
      end else if (w_wr_ok) begin
         if (cfg_net) r_tab_s[cfg_idx][32'(cfg_stage)*SWITCH_NUM +: SWITCH_NUM] <= cfg_wdata;
         else         r_tab_m[cfg_idx][32'(cfg_stage)*SWITCH_NUM +: SWITCH_NUM] <= cfg_wdata;
      end
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // next state: accepted good command starts ISSUE, last beat moves to the single HOLD cycle
   always_comb begin
      w_next = w_accept ? (w_cmd_ok ? S_ISSUE : S_IDLE) :
               (r_state == S_ISSUE) ? (w_last ? S_HOLD : S_ISSUE) : S_IDLE;
   end

   // outputs decoded from state and registered datapath
   always_comb begin
      cmd_ready       = (r_state != S_ISSUE);
      o_issue         = (r_state == S_ISSUE);
      o_module_select = r_msel;
      o_slot_select   = r_ssel;
      o_out_valid     = r_vld[PIPE_LAT-1];
      o_done          = r_lst[PIPE_LAT-1];
      o_err           = r_err;
      o_busy          = (r_state != S_IDLE) || (|r_vld);
   end

   // selects copy the table only on accept; beat counter and interconnect-latency delay lines
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_msel <= '0;
         r_ssel <= '0;
         r_cnt  <= '0;
         r_vld  <= '0;
         r_lst  <= '0;
         r_err  <= 1'b0;
      end else begin
         if (w_accept && w_cmd_ok) begin
            r_msel <= r_tab_m[cmd_cfg];
            r_ssel <= r_tab_s[cmd_cfg];
            r_cnt  <= cmd_len;
         end else if (o_issue) begin
            r_cnt  <= r_cnt - LEN_W'(1);
         end
         r_err <= w_accept && !w_cmd_ok;
         r_vld <= {r_vld[PIPE_LAT-2:0], o_issue};
         r_lst <= {r_lst[PIPE_LAT-2:0], w_last};
      end
   end
endmodule

// File: tb/tb_benes_route_sched.sv
// tb_benes_route_sched: schedule-model checked directed bench for benes_route_sched
module tb_benes_route_sched;
   localparam int NCFG = 6;
   localparam int SEL  = 144;
   localparam int N    = 1024;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            cfg_we = 1'b0;
   logic [2:0]      cfg_idx = '0;
   logic            cfg_net = 1'b0;
   logic [3:0]      cfg_stage = '0;
   logic [15:0]     cfg_wdata = '0;
   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic [2:0]      cmd_cfg = '0;
   logic [7:0]      cmd_len = '0;
   logic [SEL-1:0]  o_module_select, o_slot_select;
   logic            o_issue, o_out_valid, o_done, o_err, o_busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit e_iss [N];
   bit e_vld [N];
   bit e_done [N];
   bit e_err [N];
   bit e_busy [N];
   logic [SEL-1:0] m_tab_m [8];
   logic [SEL-1:0] m_tab_s [8];
   logic [SEL-1:0] m_msel = '0;
   logic [SEL-1:0] m_ssel = '0;

   benes_route_sched #(.NUM_CFG(NCFG), .CFG_IDX_W(3)) dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_net(cfg_net), .cfg_stage(cfg_stage), .cfg_wdata(cfg_wdata),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_cfg(cmd_cfg), .cmd_len(cmd_len),
      .o_module_select(o_module_select), .o_slot_select(o_slot_select),
      .o_issue(o_issue), .o_out_valid(o_out_valid), .o_done(o_done), .o_err(o_err), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
      end
   endtask

   task automatic chkw(input string name, input logic [SEL-1:0] act, input logic [SEL-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   // behavioural model: each accepted command paints its issue/valid/done/busy cycles into a timeline
   initial forever begin
      @(posedge clk);
      if (rst) begin
         for (int i = cyc; i < N; i++) begin
            e_iss[i] = 0; e_vld[i] = 0; e_done[i] = 0; e_err[i] = 0; e_busy[i] = 0;
         end
         for (int i = 0; i < 8; i++) begin
            m_tab_m[i] = '0;
            m_tab_s[i] = '0;
         end
         m_msel = '0;
         m_ssel = '0;
      end else begin
         if (cmd_valid && !e_iss[cyc]) begin
            if (cmd_len == 0 || int'(cmd_cfg) >= NCFG) e_err[cyc+1] = 1;
            else begin
               m_msel = m_tab_m[cmd_cfg];
               m_ssel = m_tab_s[cmd_cfg];
               for (int k = 1; k <= int'(cmd_len); k++) begin
                  e_iss[cyc+k] = 1;
                  e_vld[cyc+k+3] = 1;
               end
               for (int k = 1; k <= int'(cmd_len) + 3; k++) e_busy[cyc+k] = 1;
               e_done[cyc+int'(cmd_len)+3] = 1;
            end
         end
         if (cfg_we && int'(cfg_stage) < 9 && int'(cfg_idx) < NCFG) begin
            if (cfg_net) m_tab_s[cfg_idx][int'(cfg_stage)*16 +: 16] = cfg_wdata;
            else         m_tab_m[cfg_idx][int'(cfg_stage)*16 +: 16] = cfg_wdata;
         end
      end
      cyc++;
   end

   // compare process: every cycle, away from the active edge
   initial forever begin
      @(negedge clk);
      if (cyc < N) begin
         chk1("cmd_ready", cmd_ready, !e_iss[cyc]);
         chk1("o_issue", o_issue, e_iss[cyc]);
         chk1("o_out_valid", o_out_valid, e_vld[cyc]);
         chk1("o_done", o_done, e_done[cyc]);
         chk1("o_err", o_err, e_err[cyc]);
         chk1("o_busy", o_busy, e_busy[cyc]);
         chkw("o_module_select", o_module_select, m_msel);
         chkw("o_slot_select", o_slot_select, m_ssel);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1);
   end

   task automatic wr(input logic [2:0] i, input logic n, input logic [3:0] s, input logic [15:0] d);
      cfg_we = 1'b1; cfg_idx = i; cfg_net = n; cfg_stage = s; cfg_wdata = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic send(input logic [2:0] c, input logic [7:0] l, output int t);
      int n;
      n = 0;
      cmd_valid = 1'b1; cmd_cfg = c; cmd_len = l;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout cyc=%0d actual=not_ready required=ready", cyc);
      end
      t = cyc;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_to(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   initial begin
      int t, t2;
      logic [SEL-1:0] sm;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk1("rst_ready", cmd_ready, 1'b1);
      chkw("rst_msel", o_module_select, '0);
      wr(3'd2, 1'b0, 4'd0, 16'hA5A5);
      wr(3'd2, 1'b1, 4'd8, 16'h0F0F);
      wr(3'd1, 1'b0, 4'd1, 16'h1111);
      wr(3'd1, 1'b1, 4'd0, 16'h2222);
      wr(3'd3, 1'b0, 4'd9, 16'hFFFF);
      // single command, entry 2, four beats
      send(3'd2, 8'd4, t);
      chkw("t_msel", o_module_select, SEL'(16'hA5A5));
      chkw("t_ssel", o_slot_select, {16'h0F0F, 128'h0});
      chk1("t_issue_first", o_issue, 1'b1);
      wait_to(t + 4);
      chk1("t_issue_last", o_issue, 1'b1);
      chk1("t_valid_first", o_out_valid, 1'b1);
      wait_to(t + 5);
      chk1("t_hold_issue", o_issue, 1'b0);
      chk1("t_hold_ready", cmd_ready, 1'b1);
      wait_to(t + 7);
      chk1("t_done", o_done, 1'b1);
      wait_to(t + 8);
      chk1("t_idle_busy", o_busy, 1'b0);
      // back-to-back: second command accepted in HOLD
      send(3'd2, 8'd2, t);
      send(3'd1, 8'd3, t2);
      chkw("b2b_accept_cyc", SEL'(t2 - t), SEL'(3));
      chkw("b2b_msel", o_module_select, SEL'(32'h1111_0000));
      chkw("b2b_ssel", o_slot_select, SEL'(16'h2222));
      wait_to(t + 6);
      chk1("b2b_gap", o_out_valid, 1'b0);
      wait_to(t + 9);
      chk1("b2b_done", o_done, 1'b1);
      wait_to(cyc + 3);
      // rejected commands
      sm = o_module_select;
      send(3'd1, 8'd0, t);
      chk1("err_len0", o_err, 1'b1);
      chk1("err_len0_issue", o_issue, 1'b0);
      chkw("err_len0_sel", o_module_select, sm);
      send(3'd7, 8'd3, t);
      chk1("err_cfg7", o_err, 1'b1);
      send(3'd6, 8'd1, t);
      chk1("err_cfg6", o_err, 1'b1);
      send(3'd5, 8'd1, t);
      chk1("ok_cfg5_err", o_err, 1'b0);
      chkw("ok_cfg5_sel", o_module_select, '0);
      wait_to(cyc + 5);
      // rewrite active entry during ISSUE
      send(3'd2, 8'd4, t);
      wr(3'd2, 1'b0, 4'd0, 16'h1234);
      wait_to(t + 3);
      chkw("rw_hold_sel", o_module_select, SEL'(16'hA5A5));
      wait_to(t + 8);
      send(3'd2, 8'd1, t);
      chkw("rw_new_sel", o_module_select, SEL'(16'h1234));
      wait_to(cyc + 5);
      // write coincident with accept of the same entry
      cfg_we = 1'b1; cfg_idx = 3'd2; cfg_net = 1'b0; cfg_stage = 4'd0; cfg_wdata = 16'hBEEF;
      cmd_valid = 1'b1; cmd_cfg = 3'd2; cmd_len = 8'd1;
      @(negedge clk);
      cfg_we = 1'b0;
      cmd_valid = 1'b0;
      chkw("sim_pre_write", o_module_select, SEL'(16'h1234));
      wait_to(cyc + 5);
      send(3'd2, 8'd1, t);
      chkw("sim_post_write", o_module_select, SEL'(16'hBEEF));
      wait_to(cyc + 5);
      // async reset in the middle of a five-beat command
      send(3'd1, 8'd5, t);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk1("arst_issue", o_issue, 1'b0);
      chk1("arst_valid", o_out_valid, 1'b0);
      chk1("arst_busy", o_busy, 1'b0);
      chk1("arst_ready", cmd_ready, 1'b1);
      chkw("arst_msel", o_module_select, '0);
      chkw("arst_ssel", o_slot_select, '0);
      @(negedge clk);
      rst = 1'b0;
      wait_to(cyc + 8);
      send(3'd1, 8'd1, t);
      wait_to(t + 4);
      chk1("post_rst_done", o_done, 1'b1);
      chk1("post_rst_valid", o_out_valid, 1'b1);
      wait_to(cyc + 4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
